// File: rtl/vx_tensor_kseq.sv
// K-depth tensor sequencer: splits a 4xK * Kx4 fp32 MAC job into K/2 chained 4x2x4 DPU steps.
// Also holds the VX_tensor_dpu step engine it drives (fp32, flush-to-zero, round-to-nearest-even).

module VX_tensor_dpu #(
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic                   stall,
  input  logic [3:0][1:0][31:0]  A_tile,
  input  logic [1:0][3:0][31:0]  B_tile,
  input  logic [3:0][3:0][31:0]  C_tile,
  output logic                   valid_out,
  output logic [3:0][3:0][31:0]  D_tile
);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  function automatic logic [31:0] fp_round(input logic sgn, input int e_in,
                                           input logic [23:0] m, input logic g, input logic st);
    logic [24:0] r;
    int          e;
    e = e_in;
    r = {1'b0, m} + 25'(g && (st || m[0]));
    if (r[24]) begin
      r = r >> 1;
      e = e + 1;
    end
    if (e >= 255) return {sgn, 8'hFF, 23'h0};
    if (e <= 0)   return {sgn, 31'h0};
    return {sgn, 8'(e), r[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [47:0] p;
    int          e;
    sgn = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if (a[30:0] > 31'h7F800000 || b[30:0] > 31'h7F800000 ||
          a[30:23] == 8'h00 || b[30:23] == 8'h00) return QNAN;
      return {sgn, 8'hFF, 23'h0};
    end
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {sgn, 31'h0};
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) return fp_round(sgn, e + 1, p[47:24], p[23], |p[22:0]);
    return fp_round(sgn, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [26:0] mx, my;
    logic [27:0] s;
    int          e, d;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if (a[30:0] > 31'h7F800000 || b[30:0] > 31'h7F800000) return QNAN;
      if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return QNAN;
      return (a[30:23] == 8'hFF) ? a : b;
    end
    if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'h0};
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = int'(x[30:23]) - int'(y[30:23]);
    e  = int'(x[30:23]);
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    // Guard/round/sticky bits keep round-to-nearest-even exact across the alignment shift.
    if (d >= 27) my = 27'd1;
    else for (int i = 0; i < 26; i++) if (i < d) my = {1'b0, my[26:2], my[1] | my[0]};
    if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my};
    else                s = {1'b0, mx} - {1'b0, my};
    if (s == 28'h0) return 32'h0;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 1;
    end else begin
      for (int i = 0; i < 26; i++) if (!s[26]) begin
        s = s << 1;
        e = e - 1;
      end
    end
    return fp_round(x[31], e, s[26:3], s[2], |s[1:0]);
  endfunction

  logic [3:0][3:0][31:0] w_d;
  logic [LATENCY-1:0]    r_v;
  logic [3:0][3:0][31:0] r_d [LATENCY];

  always_comb begin
    // NOTE: every comb output gets a full assignment on each pass, so no latch is inferred.
    w_d = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        w_d[i][j] = fp_add(fp_add(C_tile[i][j], fp_mul(A_tile[i][0], B_tile[0][j])),
                           fp_mul(A_tile[i][1], B_tile[1][j]));
  end

  // NOTE: non-blocking assignments model all flops so stage-to-stage transfer is order-independent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v <= '0;
    end else if (!stall) begin
      r_v[0] <= valid_in;
      for (int k = 1; k < LATENCY; k++) r_v[k] <= r_v[k-1];
    end
  end

  // NOTE: the data pipeline is not reset; r_v qualifies it, which keeps the wide array cheap.
  always_ff @(posedge clk) begin
    if (!stall) begin
      r_d[0] <= w_d;
      for (int k = 1; k < LATENCY; k++) r_d[k] <= r_d[k-1];
    end
  end

  assign valid_out = r_v[LATENCY-1];
  assign D_tile    = r_d[LATENCY-1];
endmodule

module vx_tensor_kseq #(
  parameter int K_MAX = 8,
  parameter int SW    = $clog2(K_MAX/2 + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic [SW-1:0]                k_steps,
  input  logic                         c_zero,
  input  logic [3:0][K_MAX-1:0][31:0]  A_tile,
  input  logic [K_MAX-1:0][3:0][31:0]  B_tile,
  input  logic [3:0][3:0][31:0]        C_tile,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [3:0][3:0][31:0]        D_tile,
  output logic                         busy,
  output logic [31:0]                  perf_ops
);
  localparam int            IW     = $clog2(K_MAX);
  localparam logic [SW-1:0] KC_MAX = SW'(K_MAX/2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                      r_state;
  logic                        r_ready_in, r_valid_out, r_busy;
  logic [SW-1:0]               r_kc, r_s;
  logic [31:0]                 r_perf;
  logic [3:0][3:0][31:0]       r_acc;
  logic [3:0][K_MAX-1:0][31:0] r_a;
  logic [K_MAX-1:0][3:0][31:0] r_b;

  logic [SW-1:0]               w_kc;
  logic [IW-1:0]               w_col0, w_col1;
  logic [3:0][1:0][31:0]       w_dpu_a;
  logic [1:0][3:0][31:0]       w_dpu_b;
  logic                        w_dpu_valid_in, w_dpu_valid_out;
  logic [3:0][3:0][31:0]       w_dpu_d;

  assign w_kc           = (k_steps > KC_MAX) ? KC_MAX : k_steps;
  assign w_col0         = IW'({r_s, 1'b0});
  assign w_col1         = w_col0 | IW'(1);
  assign w_dpu_valid_in = (r_state == S_ISSUE);

  always_comb begin
    w_dpu_a = '0;
    w_dpu_b = '0;
    for (int i = 0; i < 4; i++) begin
      w_dpu_a[i][0] = r_a[i][w_col0];
      w_dpu_a[i][1] = r_a[i][w_col1];
      w_dpu_b[0][i] = r_b[w_col0][i];
      w_dpu_b[1][i] = r_b[w_col1][i];
    end
  end

  VX_tensor_dpu #(.LATENCY(2)) u_dpu (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (w_dpu_valid_in),
    .stall     (1'b0),
    .A_tile    (w_dpu_a),
    .B_tile    (w_dpu_b),
    .C_tile    (r_acc),
    .valid_out (w_dpu_valid_out),
    .D_tile    (w_dpu_d)
  );

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && valid_in) begin
      r_a <= A_tile;
      r_b <= B_tile;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ready_in  <= 1'b1;
      r_valid_out <= 1'b0;
      r_busy      <= 1'b0;
      r_kc        <= '0;
      r_s         <= '0;
      r_perf      <= '0;
      r_acc       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (valid_in) begin
          r_acc      <= c_zero ? '0 : C_tile;
          r_kc       <= w_kc;
          r_s        <= '0;
          r_ready_in <= 1'b0;
          r_busy     <= 1'b1;
          if (w_kc == '0) begin
            r_state     <= S_DONE;
            r_valid_out <= 1'b1;
          end else begin
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_perf  <= r_perf + 32'd1;
          r_state <= S_WAIT;
        end
        // Each step's result becomes the C operand of the next step.
        S_WAIT: if (w_dpu_valid_out) begin
          r_acc <= w_dpu_d;
          if (r_s == r_kc - SW'(1)) begin
            r_state     <= S_DONE;
            r_valid_out <= 1'b1;
          end else begin
            r_s     <= r_s + SW'(1);
            r_state <= S_ISSUE;
          end
        end
        S_DONE: if (ready_out) begin
          r_state     <= S_IDLE;
          r_valid_out <= 1'b0;
          r_busy      <= 1'b0;
          r_ready_in  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_in  = r_ready_in;
  assign valid_out = r_valid_out;
  assign busy      = r_busy;
  assign D_tile    = r_acc;
  assign perf_ops  = r_perf;
endmodule

// File: tb/tb_vx_tensor_kseq.sv
// Self-checking bench for vx_tensor_kseq: directed cases plus randomized jobs against an exact
// half-unit integer model of A*B+C (all operands chosen so fp32 arithmetic is exact).

module tb_vx_tensor_kseq;
  localparam int K_MAX = 8;
  localparam int SW    = $clog2(K_MAX/2 + 1);
  localparam int L     = 2;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        valid_in = 1'b0;
  logic                        ready_in;
  logic [SW-1:0]               k_steps = '0;
  logic                        c_zero = 1'b0;
  logic [3:0][K_MAX-1:0][31:0] A_tile = '0;
  logic [K_MAX-1:0][3:0][31:0] B_tile = '0;
  logic [3:0][3:0][31:0]       C_tile = '0;
  logic                        valid_out;
  logic                        ready_out = 1'b0;
  logic [3:0][3:0][31:0]       D_tile;
  logic                        busy;
  logic [31:0]                 perf_ops;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ops  = 0;
  int ma [4][K_MAX];
  int mb [K_MAX][4];
  int mc [4][4];

  vx_tensor_kseq #(.K_MAX(K_MAX)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in), .k_steps(k_steps),
    .c_zero(c_zero), .A_tile(A_tile), .B_tile(B_tile), .C_tile(C_tile), .valid_out(valid_out),
    .ready_out(ready_out), .D_tile(D_tile), .busy(busy), .perf_ops(perf_ops)
  );

  always #5 clk = ~clk;

  // Encodes the exact value h/2 as fp32 (|h| < 2^24).
  function automatic logic [31:0] half_to_fp(input int h);
    int          mag, p;
    logic [31:0] m;
    if (h == 0) return 32'h0;
    mag = (h < 0) ? -h : h;
    p = 0;
    for (int i = 0; i < 24; i++) if (mag >= (1 << i)) p = i;
    m = 32'(mag) << (23 - p);
    return {h < 0, 8'(126 + p), m[22:0]};
  endfunction

  function automatic int clamp_k(input int kst);
    return (kst > K_MAX/2) ? K_MAX/2 : kst;
  endfunction

  function automatic void set_uniform(input int a, input int b, input int c_half);
    for (int i = 0; i < 4; i++) for (int k = 0; k < K_MAX; k++) ma[i][k] = a;
    for (int k = 0; k < K_MAX; k++) for (int j = 0; j < 4; j++) mb[k][j] = b;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) mc[i][j] = c_half;
  endfunction

  function automatic void set_random();
    for (int i = 0; i < 4; i++) for (int k = 0; k < K_MAX; k++) ma[i][k] = int'($urandom_range(0, 6)) - 3;
    for (int k = 0; k < K_MAX; k++) for (int j = 0; j < 4; j++) mb[k][j] = int'($urandom_range(0, 6)) - 3;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) mc[i][j] = int'($urandom_range(0, 40)) - 20;
  endfunction

  function automatic logic [3:0][3:0][31:0] model_d(input int kst, input bit cz);
    logic [3:0][3:0][31:0] d;
    int h;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        h = cz ? 0 : mc[i][j];
        for (int k = 0; k < 2 * clamp_k(kst); k++) h += 2 * ma[i][k] * mb[k][j];
        d[i][j] = half_to_fp(h);
      end
    return d;
  endfunction

  function automatic logic [3:0][3:0][31:0] fill_const(input logic [31:0] v);
    logic [3:0][3:0][31:0] d;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) d[i][j] = v;
    return d;
  endfunction

  // Presents one job for a single cycle, then scrambles operands to prove they were captured.
  task automatic accept_job(input int kst, input bit cz, output bit rdy);
    @(negedge clk);
    rdy      = ready_in;
    k_steps  = SW'(kst);
    c_zero   = cz;
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) for (int k = 0; k < K_MAX; k++) A_tile[i][k] = half_to_fp(2 * ma[i][k]);
    for (int k = 0; k < K_MAX; k++) for (int j = 0; j < 4; j++) B_tile[k][j] = half_to_fp(2 * mb[k][j]);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) C_tile[i][j] = half_to_fp(mc[i][j]);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    k_steps  = SW'($urandom);
    for (int i = 0; i < 4; i++) for (int k = 0; k < K_MAX; k++) A_tile[i][k] = $urandom;
    for (int k = 0; k < K_MAX; k++) for (int j = 0; j < 4; j++) B_tile[k][j] = $urandom;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) C_tile[i][j] = $urandom;
  endtask

  // Returns the cycle offset (from the accept cycle) at which valid_out is first seen, -1 on timeout.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_out && n < 200);
    if (!valid_out) n = -1;
  endtask

  task automatic release_result();
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    ready_out = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ready_in, valid_out, busy} !== 3'b100) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 100", {ready_in, valid_out, busy});
    end
    n_checks++;
    if (D_tile !== '0) begin n_fail++; $display("FAIL reset_d: got %h expected 0", D_tile); end
    n_checks++;
    if (perf_ops !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d expected 0", perf_ops); end
    reset = 1'b0;
  endtask

  task automatic test_single_step();
    bit rdy; int n;
    set_uniform(1, 2, 1);
    accept_job(1, 1'b0, rdy);
    n_checks++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", rdy); end
    wait_valid(n);
    n_checks++;
    if (n !== 1 + (L + 1)) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", n, 1 + (L + 1)); end
    n_checks++;
    if (D_tile !== fill_const(32'h40900000)) begin
      n_fail++; $display("FAIL single_d: got %h expected all 40900000", D_tile);
    end
    release_result();
    exp_ops += 1;
    n_checks++;
    if (perf_ops !== 32'(exp_ops)) begin n_fail++; $display("FAIL single_perf: got %0d expected %0d", perf_ops, exp_ops); end
  endtask

  task automatic test_full_and_clamp(input int kst);
    bit rdy; int n;
    set_uniform(1, 1, 0);
    accept_job(kst, 1'b0, rdy);
    wait_valid(n);
    n_checks++;
    if (n !== 1 + 4 * (L + 1)) begin n_fail++; $display("FAIL full_latency k=%0d: got %0d expected %0d", kst, n, 1 + 4 * (L + 1)); end
    n_checks++;
    if (D_tile !== fill_const(32'h41000000)) begin
      n_fail++; $display("FAIL full_d k=%0d: got %h expected all 41000000", kst, D_tile);
    end
    release_result();
    exp_ops += 4;
    n_checks++;
    if (perf_ops !== 32'(exp_ops)) begin n_fail++; $display("FAIL full_perf k=%0d: got %0d expected %0d", kst, perf_ops, exp_ops); end
  endtask

  task automatic test_zero_kc();
    bit rdy; int n;
    set_uniform(1, 1, 6);
    accept_job(0, 1'b0, rdy);
    wait_valid(n);
    n_checks++;
    if (n !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d expected 1", n); end
    n_checks++;
    if (D_tile !== fill_const(32'h40400000)) begin
      n_fail++; $display("FAIL zero_d: got %h expected all 40400000", D_tile);
    end
    release_result();
    n_checks++;
    if (perf_ops !== 32'(exp_ops)) begin n_fail++; $display("FAIL zero_perf: got %0d expected %0d", perf_ops, exp_ops); end
  endtask

  task automatic test_c_zero();
    bit rdy; int n;
    set_uniform(1, 1, 200);
    accept_job(2, 1'b1, rdy);
    wait_valid(n);
    n_checks++;
    if (D_tile !== fill_const(32'h40800000)) begin
      n_fail++; $display("FAIL czero_d: got %h expected all 40800000", D_tile);
    end
    n_checks++;
    if (n !== 1 + 2 * (L + 1)) begin n_fail++; $display("FAIL czero_latency: got %0d expected %0d", n, 1 + 2 * (L + 1)); end
    release_result();
    exp_ops += 2;
  endtask

  task automatic test_backpressure();
    bit rdy; int n, extra;
    logic [3:0][3:0][31:0] exp_d;
    set_random();
    exp_d = model_d(2, 1'b0);
    accept_job(2, 1'b0, rdy);
    wait_valid(n);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({valid_out, ready_in} !== 2'b10 || D_tile !== exp_d) begin
        n_fail++;
        $display("FAIL bp_hold c=%0d: got v=%b r=%b d=%h expected v=1 r=0 d=%h", c, valid_out, ready_in, D_tile, exp_d);
      end
      if (c == 1) begin
        valid_in = 1'b1;
        k_steps  = SW'(1);
      end
      if (c == 2) valid_in = 1'b0;
      @(negedge clk);
    end
    release_result();
    exp_ops += 2;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid_out) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL bp_single_delivery: got %0d extra cycles expected 0", extra); end
    n_checks++;
    if ({ready_in, busy} !== 2'b10 || perf_ops !== 32'(exp_ops)) begin
      n_fail++; $display("FAIL bp_after: got r=%b b=%b ops=%0d expected r=1 b=0 ops=%0d", ready_in, busy, perf_ops, exp_ops);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit rdy; int n;
    logic [3:0][3:0][31:0] exp_d;
    set_uniform(1, 1, 0);
    accept_job(4, 1'b0, rdy);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    exp_ops = 0;
    n_checks++;
    if ({valid_out, ready_in, busy} !== 3'b010 || perf_ops !== 32'd0) begin
      n_fail++; $display("FAIL rst_abort: got v=%b r=%b b=%b ops=%0d expected v=0 r=1 b=0 ops=0", valid_out, ready_in, busy, perf_ops);
    end
    @(negedge clk);
    reset = 1'b0;
    set_uniform(2, 1, 3);
    exp_d = model_d(1, 1'b0);
    accept_job(1, 1'b0, rdy);
    wait_valid(n);
    n_checks++;
    if (n !== 1 + (L + 1)) begin n_fail++; $display("FAIL rst_new_latency: got %0d expected %0d", n, 1 + (L + 1)); end
    n_checks++;
    if (D_tile !== exp_d) begin n_fail++; $display("FAIL rst_new_d: got %h expected %h", D_tile, exp_d); end
    release_result();
    exp_ops += 1;
    n_checks++;
    if (perf_ops !== 32'(exp_ops)) begin n_fail++; $display("FAIL rst_new_perf: got %0d expected %0d", perf_ops, exp_ops); end
  endtask

  task automatic test_random_back_to_back();
    bit rdy; bit cz; int n, kst;
    logic [3:0][3:0][31:0] exp_d;
    for (int t = 0; t < 12; t++) begin
      set_random();
      kst   = int'($urandom_range(0, 7));
      cz    = 1'($urandom_range(0, 1));
      exp_d = model_d(kst, cz);
      accept_job(kst, cz, rdy);
      n_checks++;
      if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_ready t=%0d: got %b expected 1", t, rdy); end
      wait_valid(n);
      n_checks++;
      if (n !== 1 + clamp_k(kst) * (L + 1)) begin
        n_fail++; $display("FAIL rand_latency t=%0d k=%0d: got %0d expected %0d", t, kst, n, 1 + clamp_k(kst) * (L + 1));
      end
      n_checks++;
      if (D_tile !== exp_d) begin
        n_fail++; $display("FAIL rand_d t=%0d k=%0d cz=%b: got %h expected %h", t, kst, cz, D_tile, exp_d);
      end
      release_result();
      exp_ops += clamp_k(kst);
    end
    n_checks++;
    if (perf_ops !== 32'(exp_ops)) begin n_fail++; $display("FAIL rand_perf: got %0d expected %0d", perf_ops, exp_ops); end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_full_and_clamp(4);
    test_zero_kc();
    test_c_zero();
    test_full_and_clamp(7);
    test_backpressure();
    test_reset_mid_wait();
    test_random_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vx_tensor_kseq.md
# VX_tensor_kseq

K-depth sequencer for the tensor core. It accepts a 4xK by Kx4 fp32 matrix-multiply-accumulate job and splits it into K/2 consecutive 4x2x4 steps on one internal `VX_tensor_dpu` instance. The partial result of each step is fed back as the next step's C tile. It sits between the tensor issue logic and writeback, and adds a valid/ready handshake on both sides, a zero-accumulator mode and an issue counter.

## Interface
- `K_MAX`, default 8: maximum K depth. Must be even and ≥2. The block handles up to K_MAX/2 DPU steps.
- `SW`, default `$clog2(K_MAX/2+1)`: width of `k_steps`.
- `clk` in 1: clock. Single clock domain.
- `reset` in 1: asynchronous, active-high reset. Also drives the DPU reset.
- `valid_in` in 1: job request.
- `ready_in` out 1: block can accept a job. High only in IDLE.
- `k_steps` in SW: number of 4x2x4 steps, i.e. K/2. Range 0..K_MAX/2.
- `c_zero` in 1: when 1, the initial accumulator is +0.0 and `C_tile` is ignored.
- `A_tile` in [3:0][K_MAX-1:0][31:0]: A operand, row-major, fp32.
- `B_tile` in [K_MAX-1:0][3:0][31:0]: B operand, fp32.
- `C_tile` in [3:0][3:0][31:0]: addend, fp32.
- `valid_out` out 1: `D_tile` is valid.
- `ready_out` in 1: consumer accepts `D_tile`.
- `D_tile` out [3:0][3:0][31:0]: result, equal to A·B + C over the first 2·k_steps columns of A and rows of B.
- `busy` out 1: state is not IDLE.
- `perf_ops` out 32: count of DPU issues since reset. Wraps modulo 2^32.

## Operation
- **Capture.** A job is accepted when `valid_in && ready_in`. On acceptance the block registers A, B, and the initial accumulator (C_tile, or all zeros if `c_zero`).
  - It registers `kc = min(k_steps, K_MAX/2)`; larger values are clamped.
  - The step counter `s` is set to 0.
- **FSM states:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - On accept with kc≠0, go to ISSUE.
  - On accept with kc=0, go to DONE with acc equal to the initial accumulator; no DPU issue.
- **ISSUE** (exactly one cycle):
  - Drive the DPU with `valid_in=1`.
  - DPU A = A columns {2s, 2s+1}; DPU B = B rows {2s, 2s+1}; DPU C = acc.
  - Increment `perf_ops`, then go to WAIT.
- **WAIT:**
  - On DPU `valid_out`, set acc ← DPU `D_tile`.
  - If s = kc−1, go to DONE; otherwise s ← s+1 and go to ISSUE.
- **DONE:**
  - `valid_out=1` and `D_tile=acc`, held stable.
  - On `ready_out`, go to IDLE.
- **DPU control:** DPU `stall` is tied to 0. DPU `valid_in` is 0 in every state except ISSUE.
- **Spurious DPU results:** a DPU `valid_out` outside WAIT is ignored and does not update acc.
- **Arithmetic:** all arithmetic is done inside the DPU in fp32. Summation order is fixed as step 0 first, up to step kc−1, so results are bit-reproducible.
- **`valid_in` while busy:** ignored, since `ready_in`=0. Operand inputs only need to be stable in the accept cycle.

## Timing
- **Reset values:**
  - State IDLE, `ready_in`=1, `valid_out`=0, `busy`=0.
  - `D_tile`/acc=0, s=0, `perf_ops`=0.
- **Reset mid-operation:** any state returns to IDLE immediately, asynchronously. No output is produced for the aborted job. The DPU is reset with the block, so no stale result can arrive.
- **Latency.** Let L be the DPU latency, i.e. cycles from DPU `valid_in` to `valid_out`. For a job accepted in cycle T:
  - ISSUE of step 0 is at T+1.
  - Step i issues at T+1+i·(L+1).
  - `valid_out` first rises at T+1+kc·(L+1).
  - For kc=0, `valid_out` rises at T+1.
- **Throughput:** one job in flight. `ready_in` rises in the cycle after the DONE handshake, so the next accept is at the earliest handshake cycle +1.
- **Backpressure:** while `valid_out && !ready_out`, `D_tile` holds and no state advances.

## Test plan
- **Single step:** kc=1, A=1.0, B=2.0, C=0.5 everywhere, c_zero=0 -> every D element = 4.5 (0x40900000); `valid_out` at T+1+(L+1); `perf_ops`=1.
- **Full depth:** K_MAX=8, kc=4, A=1.0, B=1.0, C=0 -> every D element = 8.0 (0x41000000); `perf_ops`=4; `valid_out` at T+1+4(L+1).
- **Zero and clamp cases:**
  - kc=0, C=3.0 -> D=3.0 at T+1, no DPU issue.
  - c_zero=1, C=100.0, kc=2, A=B=1.0 -> D=4.0.
  - k_steps=7 with K_MAX=8 -> identical result and timing to kc=4.
- **Backpressure:** hold `ready_out`=0 for 5 cycles in DONE -> `D_tile` stable, `ready_in`=0, a `valid_in` pulse is ignored, and exactly one result is delivered after `ready_out` rises.
- **Reset mid-WAIT:** assert `reset` during step 1 of a kc=4 job -> `valid_out`=0, `ready_in`=1, `perf_ops`=0. A new kc=1 job then produces the correct result with no leftover output from the aborted job.
